// File: rtl/register_file_mp_if.sv
// Register file access bundle: decode-side reads, writeback-side writes, clear request and ready.
// master = core side driving addresses/writes, slave = register file returning read data.
interface register_file_mp_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NR   = 2
);
  logic                 clr;
  logic                 ready;
  logic                 we0;
  logic [AW-1:0]        wa0;
  logic [XLEN-1:0]      wd0;
  logic                 we1;
  logic [AW-1:0]        wa1;
  logic [XLEN-1:0]      wd1;
  logic [NR*AW-1:0]     ra;
  logic [NR*XLEN-1:0]   rd;

  modport master (
    output clr, we0, wa0, wd0, we1, wa1, wd1, ra,
    input  ready, rd
  );

  modport slave (
    input  clr, we0, wa0, wd0, we1, wa1, wd1, ra,
    output ready, rd
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port integer register file: NR async read ports (0 latency), two prioritised write ports.
// No backpressure; while the clear sweep runs (L cycles) ready=0, writes are dropped and reads return 0.
module register_file_mp #(
  parameter int XLEN   = 32,
  parameter int L      = 32,
  parameter int AW     = 5,
  parameter int NR     = 2,
  parameter int BYPASS = 0
) (
  input  logic               clk,
  input  logic               reset,
  register_file_mp_if.slave  bus
);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [XLEN-1:0]     rf [1:L-1];
  logic                idle;
  logic                w0_ok, w1_ok;
  logic [NR*XLEN-1:0]  rd_d;

  assign idle = (state_q == IDLE);

  // A write is real only in IDLE, to a non-zero, existing entry.
  assign w1_ok = idle && bus.we1 && (bus.wa1 != '0) && (int'(bus.wa1) < L);
  assign w0_ok = idle && bus.we0 && (bus.wa0 != '0) && (int'(bus.wa0) < L);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      CLEAR: begin
        if (idx_q == AW'(L-1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      IDLE: begin
        if (bus.clr) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Entry 0 is not stored; port 1 overrides port 0 on an address collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 1; i < L; i++) begin
        if (!idle) begin
          if (idx_q == AW'(i)) rf[i] <= '0;
        end else if (w1_ok && (bus.wa1 == AW'(i))) begin
          rf[i] <= bus.wd1;
        end else if (w0_ok && (bus.wa0 == AW'(i))) begin
          rf[i] <= bus.wd0;
        end
      end
    end
  end

  always_comb begin
    rd_d = '0;
    for (int p = 0; p < NR; p++) begin
      if (idle) begin
        for (int i = 1; i < L; i++) begin
          if (bus.ra[p*AW +: AW] == AW'(i)) rd_d[p*XLEN +: XLEN] = rf[i];
        end
        if (BYPASS != 0) begin
          if (w1_ok && (bus.wa1 == bus.ra[p*AW +: AW])) begin
            rd_d[p*XLEN +: XLEN] = bus.wd1;
          end else if (w0_ok && (bus.wa0 == bus.ra[p*AW +: AW])) begin
            rd_d[p*XLEN +: XLEN] = bus.wd0;
          end
        end
      end
    end
  end

  assign bus.rd    = rd_d;
  assign bus.ready = idle;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: three register files (L=32 plain, L=32 bypass, L=16 plain) checked against hand-computed values.
module tb_register_file_mp;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  register_file_mp_if #(.XLEN(32), .AW(5), .NR(2)) ifa ();
  register_file_mp_if #(.XLEN(32), .AW(5), .NR(2)) ifb ();
  register_file_mp_if #(.XLEN(32), .AW(5), .NR(2)) ifc ();

  register_file_mp #(.XLEN(32), .L(32), .AW(5), .NR(2), .BYPASS(0)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  register_file_mp #(.XLEN(32), .L(32), .AW(5), .NR(2), .BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );
  register_file_mp #(.XLEN(32), .L(16), .AW(5), .NR(2), .BYPASS(0)) dut_c (
    .clk(clk), .reset(reset), .bus(ifc)
  );

  // The bypass instance sees exactly the same stimulus as the plain one.
  assign ifb.clr = ifa.clr;
  assign ifb.we0 = ifa.we0;
  assign ifb.wa0 = ifa.wa0;
  assign ifb.wd0 = ifa.wd0;
  assign ifb.we1 = ifa.we1;
  assign ifb.wa1 = ifa.wa1;
  assign ifb.wd1 = ifa.wd1;
  assign ifb.ra  = ifa.ra;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Count negedges with ready low on the L=32 plain instance, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      if (ifa.ready) break;
      n++;
      @(negedge clk);
    end
  endtask

  int          n;
  int          ca, cc;
  logic [31:0] exp;

  initial begin
    reset = 1'b1;
    ifa.clr = 0; ifa.we0 = 0; ifa.wa0 = '0; ifa.wd0 = '0;
    ifa.we1 = 0; ifa.wa1 = '0; ifa.wd1 = '0; ifa.ra = '0;
    ifc.clr = 0; ifc.we0 = 0; ifc.wa0 = '0; ifc.wd0 = '0;
    ifc.we1 = 0; ifc.wa1 = '0; ifc.wd1 = '0; ifc.ra = '0;

    // Reset and initial sweep
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_ready_a", ifa.ready, 0);
    check("rst_ready_c", ifc.ready, 0);
    ifa.ra = {5'd9, 5'd5};
    ca = 0; cc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 3) begin
        check("sweep_rd_a", ifa.rd[31:0], 0);
        check("sweep_rd_b", ifb.rd[63:32], 0);
      end
      if (!ifa.ready) ca++;
      if (!ifc.ready) cc++;
      if (ifa.ready && ifc.ready) break;
    end
    check("init_len_a", ca, 32);
    check("init_len_c", cc, 16);
    check("init_ready_b", ifb.ready, 1);

    for (int i = 0; i < 32; i++) begin
      ifa.ra = {5'(31 - i), 5'(i)};
      #1;
      check("init_rd0", ifa.rd[31:0], 0);
      check("init_rd1", ifa.rd[63:32], 0);
    end
    @(negedge clk);

    // Single write, read back; plain vs bypass before the edge
    ifa.we0 = 1; ifa.wa0 = 5'd5; ifa.wd0 = 32'hDEADBEEF; ifa.ra = {5'd0, 5'd5};
    #1;
    check("wr5_nobyp", ifa.rd[31:0], 0);
    check("wr5_byp", ifb.rd[31:0], 32'hDEADBEEF);
    @(negedge clk);
    ifa.we0 = 0;
    #1;
    check("wr5_rd", ifa.rd[31:0], 32'hDEADBEEF);
    check("wr5_x0", ifa.rd[63:32], 0);

    // Collision: port 1 wins
    @(negedge clk);
    ifa.we0 = 1; ifa.wa0 = 5'd7; ifa.wd0 = 32'h11;
    ifa.we1 = 1; ifa.wa1 = 5'd7; ifa.wd1 = 32'h22;
    ifa.ra = {5'd7, 5'd7};
    #1;
    check("coll_byp", ifb.rd[31:0], 32'h22);
    check("coll_old", ifa.rd[63:32], 0);
    @(negedge clk);
    ifa.we0 = 0; ifa.we1 = 0;
    #1;
    check("coll_rd_a", ifa.rd[31:0], 32'h22);
    check("coll_rd_b", ifb.rd[63:32], 32'h22);

    // Write to x0 is dropped, including from the bypass path
    @(negedge clk);
    ifa.we0 = 1; ifa.wa0 = 5'd0; ifa.wd0 = 32'hFFFFFFFF; ifa.ra = {5'd0, 5'd0};
    #1;
    check("x0_byp", ifb.rd[31:0], 0);
    @(negedge clk);
    ifa.we0 = 0;
    #1;
    check("x0_rd", ifa.rd[31:0], 0);

    // Port 1 bypass onto read port 1
    @(negedge clk);
    ifa.we1 = 1; ifa.wa1 = 5'd9; ifa.wd1 = 32'hABCD; ifa.ra = {5'd9, 5'd5};
    #1;
    check("byp9_b", ifb.rd[63:32], 32'hABCD);
    check("byp9_a_old", ifa.rd[63:32], 0);
    check("byp9_b_arr", ifb.rd[31:0], 32'hDEADBEEF);
    @(negedge clk);
    ifa.we1 = 0;
    #1;
    check("byp9_a_new", ifa.rd[63:32], 32'hABCD);

    // Distinct addresses on both write ports
    @(negedge clk);
    ifa.we0 = 1; ifa.wa0 = 5'd3; ifa.wd0 = 32'h33;
    ifa.we1 = 1; ifa.wa1 = 5'd4; ifa.wd1 = 32'h44;
    ifa.ra = {5'd3, 5'd4};
    #1;
    check("dual_byp1", ifb.rd[63:32], 32'h33);
    check("dual_byp0", ifb.rd[31:0], 32'h44);
    @(negedge clk);
    ifa.we0 = 0; ifa.we1 = 0;
    #1;
    check("dual_rd1", ifa.rd[63:32], 32'h33);
    check("dual_rd0", ifa.rd[31:0], 32'h44);

    // Fill 1..31, read back
    @(negedge clk);
    for (int i = 1; i < 32; i++) begin
      ifa.we0 = 1; ifa.wa0 = 5'(i); ifa.wd0 = 32'h1000 + i;
      @(negedge clk);
    end
    ifa.we0 = 0;
    for (int i = 0; i < 32; i++) begin
      ifa.ra = {5'd0, 5'(i)};
      exp = (i == 0) ? 32'h0 : 32'h1000 + i;
      #1;
      check("fill_rd", ifa.rd[31:0], exp);
    end
    @(negedge clk);

    // L=16 instance: out-of-range address dropped and read as zero
    ifc.we0 = 1; ifc.wa0 = 5'd20; ifc.wd0 = 32'hAAAA;
    ifc.we1 = 1; ifc.wa1 = 5'd15; ifc.wd1 = 32'h1515;
    ifc.ra = {5'd15, 5'd20};
    @(negedge clk);
    ifc.we0 = 0; ifc.we1 = 0;
    #1;
    check("l16_ra20", ifc.rd[31:0], 0);
    check("l16_ra15", ifc.rd[63:32], 32'h1515);
    ifc.ra = {5'd4, 5'd20};
    #1;
    check("l16_alias4", ifc.rd[63:32], 0);
    @(negedge clk);

    // Clear request; writes during the sweep are dropped
    ifa.clr = 1; ifa.we1 = 1; ifa.wa1 = 5'd2; ifa.wd1 = 32'h5555;
    @(negedge clk);
    ifa.clr = 0;
    ifa.we0 = 1; ifa.wa0 = 5'd1; ifa.wd0 = 32'h77;
    ifa.we1 = 1; ifa.wa1 = 5'd2; ifa.wd1 = 32'h88;
    ifa.ra = {5'd2, 5'd1};
    #1;
    check("clr_byp_rd0", ifb.rd[31:0], 0);
    check("clr_byp_rd1", ifb.rd[63:32], 0);
    wait_ready(n);
    ifa.we0 = 0; ifa.we1 = 0;
    check("clr_len", n, 32);
    for (int i = 0; i < 32; i++) begin
      ifa.ra = {5'(i), 5'(i)};
      #1;
      check("clr_rd_a", ifa.rd[31:0], 0);
      check("clr_rd_b", ifb.rd[63:32], 0);
    end
    @(negedge clk);

    // Reset in the middle of a sweep restarts it from entry 0
    ifa.clr = 1;
    @(negedge clk);
    ifa.clr = 0;
    repeat (20) @(negedge clk);
    check("mid_busy", ifa.ready, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_ready(n);
    check("mid_rst_len", n, 32);
    ifa.ra = {5'd31, 5'd20};
    #1;
    check("mid_rd20", ifa.rd[31:0], 0);
    check("mid_ready_c", ifc.ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
